// File: rtl/bus_resp_pkg.sv
// Purpose: shared types and constants for the bus register responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package bus_resp_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // Constant returned by the identification register when it is compiled in.
  localparam logic [DATA_W-1:0] RESP_ID = 8'hA5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    GRANT     = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_resp_arb.sv
// Purpose: bus grant arbiter; a local frame-update lock withholds new grants.
// Latency: int_gnt is registered, high one cycle after int_req when unlocked.
// Backpressure: lock_in stalls a pending request; an active grant is never pre-empted.
module bus_resp_arb
  import bus_resp_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic int_req,
  input  logic lock_in,
  output logic int_gnt
);

  arb_state_t state;
  arb_state_t state_nxt;

  // Next-state decode; lock_in only matters before the grant is given.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (int_req) state_nxt = lock_in ? WAIT_LOCK : GRANT;
      end
      WAIT_LOCK: begin
        if (!int_req)      state_nxt = IDLE;
        else if (!lock_in) state_nxt = GRANT;
      end
      GRANT: begin
        if (!int_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; the grant flop tracks the state so it is high exactly in GRANT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      int_gnt <= 1'b0;
    end else begin
      state   <= state_nxt;
      int_gnt <= (state_nxt == GRANT);
    end
  end

endmodule

// File: rtl/bus_reg_responder.sv
// Purpose: granted byte-wide register bank with address decode (optional ID register: BUS_REG_RESPONDER_ID_EN).
// Latency: writes land on the next edge with a one-cycle wr_pulse; read data appears one cycle after int_read.
// Backpressure: accesses are only honoured while int_gnt is high; others are silently dropped.
module bus_reg_responder
  import bus_resp_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        int_address,
  input  logic [DATA_W-1:0]        int_wr_data,
  input  logic                     int_write,
  input  logic                     int_read,
  output logic [DATA_W-1:0]        int_rd_data,
  input  logic                     int_req,
  output logic                     int_gnt,
  input  logic                     lock_in,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_val;

  bus_resp_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .int_req (int_req),
    .lock_in (lock_in),
    .int_gnt (int_gnt)
  );

  // Modulo-2^16 offset makes a window that wraps past 16'hFFFF decode naturally.
  assign offset   = int_address - BASE_ADDR;
  assign in_range = ({1'b0, offset} < NUM_REGS_X);
  assign idx      = offset[IDX_W-1:0];
  assign wr_acc   = int_write & int_gnt & in_range;
  assign rd_acc   = int_read & int_gnt;

  // Read mux: register bank, then the optional ID register, otherwise zero.
  always_comb begin
    rd_val = '0;
    if (in_range) begin
      rd_val = regs[idx];
    end
`ifdef BUS_REG_RESPONDER_ID_EN
    else if ({1'b0, offset} == NUM_REGS_X) begin
      rd_val = RESP_ID;
    end
`endif
  end

  // Register bank, write strobe and read data; a same-cycle read sees the old value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse    <= '0;
      int_rd_data <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_acc) begin
        regs[idx]     <= int_wr_data;
        wr_pulse[idx] <= 1'b1;
      end
      if (rd_acc) int_rd_data <= rd_val;
    end
  end

  // Flatten the bank: register i occupies bits [8i+7:8i].
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: doc/bus_reg_responder.md
BUS_REG_RESPONDER -- requirements
Module: bus_reg_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, meaning the number of 8-bit read/write registers (range 1..256).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000, meaning the bus address of register 0.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port int_address, input, 16 bits: byte address from the bus initiator.
REQ-006 SHALL have port int_wr_data, input, 8 bits: write data.
REQ-007 SHALL have port int_write, input, 1 bit: write strobe, one cycle per byte.
REQ-008 SHALL have port int_read, input, 1 bit: read strobe, one cycle per byte.
REQ-009 SHALL have port int_rd_data, output, 8 bits: read data.
REQ-010 SHALL have port int_req, input, 1 bit: bus access request.
REQ-011 SHALL have port int_gnt, output, 1 bit: bus access grant.
REQ-012 SHALL have port lock_in, input, 1 bit: local frame-update lock; it withholds a new grant.
REQ-013 SHALL have port reg_out, output, NUM_REGS*8 bits: flat register contents, with register i at bits [8i+7:8i].
REQ-014 SHALL have port wr_pulse, output, NUM_REGS bits: one-hot, one-cycle strobe marking the register just written.

Function
REQ-015 SHALL implement the grant FSM with states IDLE, WAIT_LOCK and GRANT.
REQ-016 SHALL make these FSM transitions:
- IDLE with int_req=1 and lock_in=0 -> GRANT.
- IDLE with int_req=1 and lock_in=1 -> WAIT_LOCK.
- WAIT_LOCK with lock_in=0 and int_req=1 -> GRANT.
- WAIT_LOCK with int_req=0 -> IDLE.
- GRANT with int_req=0 -> IDLE.
REQ-017 SHALL drive int_gnt as a registered output that is high exactly while the state is GRANT, giving 1 cycle of latency from int_req to int_gnt.
REQ-018 SHALL ignore lock_in while in GRANT, so a grant is never pre-empted.
REQ-019 SHALL decode the address as in range when (int_address - BASE_ADDR), computed modulo 2^16, is less than NUM_REGS, giving index idx.
REQ-020 SHALL, on int_write with int_gnt=1 and an in-range address, update register idx on the next edge and pulse wr_pulse[idx] high for that one cycle.
REQ-021 SHALL ignore writes when int_gnt=0 or the address is out of range: no register changes and wr_pulse stays 0.
REQ-022 SHALL register int_rd_data on the cycle after int_read with int_gnt=1, giving 1 cycle of read latency.
REQ-023 SHALL hold int_rd_data at its previous value on every cycle without an accepted read.
REQ-024 SHALL return 8'h00 for an accepted read of an out-of-range address.
REQ-025 SHALL handle int_write and int_read asserted together to the same address by returning the old value on the read and storing the new value.
REQ-026 SHALL handle an address that wraps past 16'hFFFF with the modulo arithmetic of REQ-019, with no special casing.

Reset
REQ-027 SHALL, when reset is high at a clock edge, set the state to IDLE, int_gnt=0, int_rd_data=8'h00, every register=8'h00 and wr_pulse=0.
REQ-028 SHALL give reset priority over all other inputs.
REQ-029 SHALL handle reset in the middle of a grant by forcing int_gnt low on the next cycle; the initiator re-requests.

Configuration
REQ-030 SHALL use the macro BUS_REG_RESPONDER_ID_EN to compile in or out the identification register.
REQ-031 SHALL, when BUS_REG_RESPONDER_ID_EN is defined, read the constant RESP_ID=8'hA5 at address BASE_ADDR+NUM_REGS; writes to that address are ignored and raise no wr_pulse.
REQ-032 SHALL, when BUS_REG_RESPONDER_ID_EN is undefined, treat that address as out of range (reads return 8'h00).

Structure
REQ-033 SHALL place the FSM state enum, RESP_ID and the address/data widths (16 and 8) in the shared package bus_resp_pkg.
REQ-034 SHALL implement the grant FSM (REQ-015..018) in the sub-module bus_resp_arb, and the register bank and decode in bus_reg_responder.

Verification
REQ-035 SHALL cover: reset; int_req=1 with lock_in=0 -> int_gnt=1 one cycle later; write 8'h3C to BASE_ADDR+2 -> reg_out[23:16]=8'h3C and wr_pulse=16'h0004 for one cycle.
REQ-036 SHALL cover: lock_in=1 with int_req=1 for 5 cycles -> int_gnt stays 0; lock_in falls -> int_gnt=1 one cycle later; lock_in rises during the grant -> int_gnt stays 1.
REQ-037 SHALL cover: write with int_gnt=0 -> register unchanged and wr_pulse=0; read of BASE_ADDR+NUM_REGS+1 -> int_rd_data=8'h00.
REQ-038 SHALL cover: register 5 holds 8'h11, then a simultaneous write of 8'h22 and read at index 5 -> int_rd_data=8'h11, and a following read returns 8'h22.
REQ-039 SHALL cover: BASE_ADDR=16'hFFF8, NUM_REGS=16, write to 16'h0003 -> register 11 updated; with BUS_REG_RESPONDER_ID_EN defined, read of 16'h0008 -> 8'hA5, and without it -> 8'h00.
REQ-040 SHALL cover: reset asserted while in GRANT with registers loaded -> int_gnt=0, all reg_out=0, int_rd_data=0 on the next cycle.
